prime_stream_gen: RTL and testbench

//  Sequential prime generator: from a start value, emits the next N primes (or N offset-prime pairs)
//  one per valid/ready beat, by trial division with one divisor tested per clock.

---
 rtl/prime_pkg.sv | 18 +
 rtl/prime_trial_div.sv | 51 +++++
 rtl/prime_stream_gen.sv | 175 +++++++++++++++++
 tb/tb_prime_stream_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/prime_pkg.sv
// Shared types and helpers for the prime stream generator.
package prime_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_TEST      = 3'd2,
    ST_PAIR_TEST = 3'd3,
    ST_EMIT      = 3'd4,
    ST_FINISH    = 3'd5
  } state_e;

  // Unsigned maximum, used to clamp the start candidate to 2.
  function automatic logic [31:0] umax(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/prime_trial_div.sv
// Trial divider: holds one value and tests one divisor per enabled cycle.
// is_prime / is_comp are combinational verdicts on the current divisor.
module prime_trial_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             is_prime,
  output logic             is_comp
);

  logic [WIDTH-1:0]   val_q, val_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [2*WIDTH-1:0] div_sq;
  logic [WIDTH-1:0]   rem;
  logic               sq_gt;

  // Full-width square so the d*d > value test never truncates.
  assign div_sq   = {{WIDTH{1'b0}}, div_q} * {{WIDTH{1'b0}}, div_q};
  assign sq_gt    = div_sq > {{WIDTH{1'b0}}, val_q};
  assign rem      = val_q % div_q;
  assign is_prime = en && sq_gt;
  assign is_comp  = en && !sq_gt && (rem == '0);

  // Next value/divisor: a load restarts at d=2, otherwise step d while undecided.
  always_comb begin
    val_d = val_q;
    div_d = div_q;
    if (load) begin
      val_d = load_val;
      div_d = WIDTH'(2);
    end else if (en && !sq_gt && (rem != '0)) begin
      div_d = div_q + WIDTH'(1);
    end
  end

  // Divisor starts at 2 out of reset so the modulo never sees zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      div_q <= WIDTH'(2);
    end else begin
      val_q <= val_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/prime_stream_gen.sv
// Sequential prime (or prime-pair) source with valid/ready output beats.
module prime_stream_gen
  import prime_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_W     = 8,
  parameter int PAIR_MODE = 0,
  parameter int OFFSET    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] start_value,
  input  logic [CNT_W-1:0] req_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] prime_out,
  output logic [WIDTH-1:0] pair_out,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam logic [WIDTH:0] MAX_V = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] OFF_V = (WIDTH+1)'(OFFSET);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sv_q, sv_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] prime_q, prime_d;
  logic [WIDTH-1:0] pair_q, pair_d;
  logic             ovf_q, ovf_d;

  logic             div_load, div_en, is_prime, is_comp;
  logic [WIDTH-1:0] div_val, cand_init, cand_inc;
  logic [WIDTH:0]   pair_sum;
  logic             at_max, pair_wraps;

  assign cand_init  = WIDTH'(umax(32'(sv_q), 32'd2));
  assign cand_inc   = cand_q + WIDTH'(1);
  assign pair_sum   = {1'b0, cand_q} + OFF_V;
  assign at_max     = (cand_q == {WIDTH{1'b1}});
  assign pair_wraps = pair_sum > MAX_V;

  prime_trial_div #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .load_val (div_val),
    .en       (div_en),
    .is_prime (is_prime),
    .is_comp  (is_comp)
  );

  // Request FSM: walk candidates, verify optional pair partner, hold beat until accepted.
  always_comb begin
    state_d  = state_q;
    sv_d     = sv_q;
    count_d  = count_q;
    cand_d   = cand_q;
    prime_d  = prime_q;
    pair_d   = pair_q;
    ovf_d    = ovf_q;
    div_load = 1'b0;
    div_val  = cand_inc;
    div_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sv_d    = start_value;
          count_d = req_count;
          ovf_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cand_d   = cand_init;
        div_load = 1'b1;
        div_val  = cand_init;
        state_d  = (count_q == '0) ? ST_FINISH : ST_TEST;
      end
      ST_TEST: begin
        div_en = 1'b1;
        if (is_prime) begin
          if (PAIR_MODE != 0) begin
            if (pair_wraps) begin
              ovf_d   = 1'b1;
              state_d = ST_FINISH;
            end else begin
              div_load = 1'b1;
              div_val  = pair_sum[WIDTH-1:0];
              state_d  = ST_PAIR_TEST;
            end
          end else begin
            prime_d = cand_q;
            pair_d  = '0;
            state_d = ST_EMIT;
          end
        end else if (is_comp) begin
          if (at_max) begin
            ovf_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            cand_d   = cand_inc;
            div_load = 1'b1;
          end
        end
      end
      ST_PAIR_TEST: begin
        div_en = 1'b1;
        if (is_prime) begin
          prime_d = cand_q;
          pair_d  = pair_sum[WIDTH-1:0];
          state_d = ST_EMIT;
        end else if (is_comp) begin
          if (at_max) begin
            ovf_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            cand_d   = cand_inc;
            div_load = 1'b1;
            state_d  = ST_TEST;
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d = ST_FINISH;
          end else if (at_max) begin
            ovf_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            cand_d   = cand_inc;
            div_load = 1'b1;
            state_d  = ST_TEST;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sv_q    <= '0;
      count_q <= '0;
      cand_q  <= '0;
      prime_q <= '0;
      pair_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sv_q    <= sv_d;
      count_q <= count_d;
      cand_q  <= cand_d;
      prime_q <= prime_d;
      pair_q  <= pair_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == ST_EMIT);
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done      = (state_q == ST_FINISH);
  assign prime_out = prime_q;
  assign pair_out  = pair_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_prime_stream_gen.sv
// Directed bench for prime_stream_gen: three configurations, scoreboarded beats.
module tb_prime_stream_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // A: WIDTH=16 single primes; B: pair mode offset 2; C: WIDTH=8 for wrap.
  logic        a_start = 0, a_ready = 0, a_valid, a_busy, a_done, a_ov;
  logic [15:0] a_sv = 0, a_p, a_pr;
  logic [7:0]  a_cnt = 0;
  logic        b_start = 0, b_ready = 0, b_valid, b_busy, b_done, b_ov;
  logic [15:0] b_sv = 0, b_p, b_pr;
  logic [7:0]  b_cnt = 0;
  logic        c_start = 0, c_ready = 0, c_valid, c_busy, c_done, c_ov;
  logic [7:0]  c_sv = 0, c_p, c_pr;
  logic [7:0]  c_cnt = 0;

  prime_stream_gen #(.WIDTH(16), .CNT_W(8), .PAIR_MODE(0), .OFFSET(2)) ua (
    .clk(clk), .rst(rst), .start(a_start), .start_value(a_sv), .req_count(a_cnt),
    .out_valid(a_valid), .out_ready(a_ready), .prime_out(a_p), .pair_out(a_pr),
    .busy(a_busy), .done(a_done), .overflow(a_ov));

  prime_stream_gen #(.WIDTH(16), .CNT_W(8), .PAIR_MODE(1), .OFFSET(2)) ub (
    .clk(clk), .rst(rst), .start(b_start), .start_value(b_sv), .req_count(b_cnt),
    .out_valid(b_valid), .out_ready(b_ready), .prime_out(b_p), .pair_out(b_pr),
    .busy(b_busy), .done(b_done), .overflow(b_ov));

  prime_stream_gen #(.WIDTH(8), .CNT_W(8), .PAIR_MODE(0), .OFFSET(2)) uc (
    .clk(clk), .rst(rst), .start(c_start), .start_value(c_sv), .req_count(c_cnt),
    .out_valid(c_valid), .out_ready(c_ready), .prime_out(c_p), .pair_out(c_pr),
    .busy(c_busy), .done(c_done), .overflow(c_ov));

  int n_assert = 0;
  int n_fail   = 0;
  int exp_p[$];
  int exp_pr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input int s, output logic v, output logic [15:0] p,
                        output logic [15:0] pr, output logic dn, output logic bsy,
                        output logic ov, output logic rdy);
    case (s)
      0: begin v = a_valid; p = a_p; pr = a_pr; dn = a_done; bsy = a_busy; ov = a_ov; rdy = a_ready; end
      1: begin v = b_valid; p = b_p; pr = b_pr; dn = b_done; bsy = b_busy; ov = b_ov; rdy = b_ready; end
      default: begin
        v = c_valid; p = {8'h0, c_p}; pr = {8'h0, c_pr}; dn = c_done;
        bsy = c_busy; ov = c_ov; rdy = c_ready;
      end
    endcase
  endtask

  task automatic kick(input int s, input logic [15:0] sv, input logic [7:0] cnt);
    @(posedge clk); #1;
    case (s)
      0: begin a_start = 1; a_sv = sv; a_cnt = cnt; end
      1: begin b_start = 1; b_sv = sv; b_cnt = cnt; end
      default: begin c_start = 1; c_sv = sv[7:0]; c_cnt = cnt; end
    endcase
    @(posedge clk); #1;
    a_start = 0; b_start = 0; c_start = 0;
  endtask

  // Drain one request: compare every accepted beat against the queue, wait for done.
  task automatic run(input int s, input int budget, input logic exp_ov, input string tag);
    logic v, dn, bsy, ov, rdy;
    logic [15:0] p, pr;
    bit fin = 0;
    case (s)
      0: a_ready = 1;
      1: b_ready = 1;
      default: c_ready = 1;
    endcase
    for (int i = 0; i < budget && !fin; i++) begin
      @(negedge clk);
      sample(s, v, p, pr, dn, bsy, ov, rdy);
      if (v && rdy) begin
        if (exp_p.size() == 0) chk({tag, "_extra_beat_valid"}, v, 0);
        else begin
          chk({tag, "_prime"}, p, exp_p.pop_front());
          chk({tag, "_pair"}, pr, exp_pr.pop_front());
        end
      end
      if (dn) begin
        fin = 1;
        chk({tag, "_busy_at_done"}, bsy, 0);
      end
    end
    chk({tag, "_done_seen"}, fin, 1);
    chk({tag, "_beats_left"}, exp_p.size(), 0);
    chk({tag, "_overflow"}, ov, exp_ov);
    exp_p.delete();
    exp_pr.delete();
    @(negedge clk);
    sample(s, v, p, pr, dn, bsy, ov, rdy);
    chk({tag, "_done_one_cycle"}, dn, 0);
    chk({tag, "_busy_after"}, bsy, 0);
  endtask

  initial begin
    logic v, dn, bsy, ov, rdy;
    logic [15:0] p, pr;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", a_valid, 0);
    chk("rst_prime", a_p, 0);
    chk("rst_pair", a_pr, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_overflow", a_ov, 0);
    @(posedge clk); #1;
    rst = 0;

    // First five primes
    exp_p = '{2, 3, 5, 7, 11};  exp_pr = '{0, 0, 0, 0, 0};
    kick(0, 16'd2, 8'd5);
    run(0, 500, 0, "first5");

    // Next prime above 14
    exp_p = '{17};  exp_pr = '{0};
    kick(0, 16'd14, 8'd1);
    run(0, 200, 0, "from14");

    // Start below 2 is clamped to 2
    exp_p = '{2};  exp_pr = '{0};
    kick(0, 16'd0, 8'd1);
    run(0, 200, 0, "from0");

    // Zero-count request: busy in LOAD, done two cycles after start, no beat
    kick(0, 16'd500, 8'd0);
    @(negedge clk);
    chk("cnt0_busy_load", a_busy, 1);
    chk("cnt0_done_early", a_done, 0);
    @(negedge clk);
    chk("cnt0_done", a_done, 1);
    chk("cnt0_valid", a_valid, 0);
    @(negedge clk);
    chk("cnt0_done_pulse", a_done, 0);

    // Backpressure on first beat
    a_ready = 0;
    exp_p = '{101, 103};  exp_pr = '{0, 0};
    kick(0, 16'd100, 8'd2);
    for (int i = 0; i < 300 && !a_valid; i++) @(negedge clk);
    chk("stall_valid_rise", a_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid_hold", a_valid, 1);
      chk("stall_prime_hold", a_p, 101);
    end
    @(posedge clk); #1;
    run(0, 300, 0, "stall");

    // Start ignored while busy
    exp_p = '{2, 3};  exp_pr = '{0, 0};
    a_ready = 0;
    kick(0, 16'd2, 8'd2);
    kick(0, 16'd200, 8'd1);
    @(posedge clk); #1;
    run(0, 300, 0, "busy_ign");

    // Twin-prime pairs
    exp_p = '{3, 5, 11};  exp_pr = '{5, 7, 13};
    kick(1, 16'd3, 8'd3);
    run(1, 500, 0, "pairs");

    // 8-bit wrap: 251 then overflow without a second beat
    exp_p = '{251};  exp_pr = '{0};
    kick(2, 16'd250, 8'd2);
    run(2, 500, 1, "wrap8");

    // Overflow cleared by the next accepted start
    exp_p = '{2};  exp_pr = '{0};
    kick(2, 16'd2, 8'd1);
    run(2, 200, 0, "wrap8_clear");

    // Reset in the middle of TEST
    kick(0, 16'd65000, 8'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_busy_before", a_busy, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("midrst_busy", a_busy, 0);
    chk("midrst_valid", a_valid, 0);
    chk("midrst_prime", a_p, 0);
    chk("midrst_overflow", a_ov, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sample(0, v, p, pr, dn, bsy, ov, rdy);
      chk("midrst_no_done", dn, 0);
    end

    // Fresh request after reset
    exp_p = '{2, 3};  exp_pr = '{0, 0};
    kick(0, 16'd1, 8'd2);
    run(0, 300, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
